lamp_fpu_goldschmidt_sqrt: RTL
==============================

# lamp_fpu_goldschmidt_sqrt

Parametrised, iteration-bounded Goldschmidt unit that computes sqrt(s) or 1/sqrt(s) of a normalised mantissa s in [0.5, 2). It sits in the lampFPU datapath between the exponent-halving front end and the normaliser/rounder. It generalises the fixed-width fraction-sqrt stage with:
- configurable width, guard bits, seed width and iteration count;
- a start/busy/valid handshake;
- out-of-range detection;
- optional rounding.

## Interface
- F_DW, default 7: mantissa fraction bits.
- PREC_DW, default 8: internal guard bits; must be ≥ F_DW+1.
- LUT_DW, default 4: seed table fraction bits.
- ITERS, default 2: Goldschmidt iterations, range 1..15.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  operation request; sampled only in IDLE.
- op_i  in  1  0 = sqrt, 1 = inverse sqrt; captured with start_i.
- s_i  in  F_DW+1  mantissa.
  - Value is s_i / 2^F_DW.
  - Either form 1.F (msb 1) or 0.1F (top bits 01).
  - Captured with start_i.
- result_o  out  2*(F_DW+1)  result, 1 integer bit and 2*F_DW+1 fraction bits.
- valid_o  out  1  one-cycle pulse: result_o/err_o are valid.
- busy_o  out  1  high in every state except IDLE.
- err_o  out  1  input was out of range (s_i < 2^(F_DW-1)); qualified by valid_o.

## Operation
- Internal width W = 2+F_DW+PREC_DW: 2 integer bits, FW = F_DW+PREC_DW fraction bits.
- All products are truncated back to FW fraction bits.
- Seed table:
  - Index i = s_i[F_DW -: LUT_DW+1].
  - y0 = round(2^LUT_DW / sqrt((i+0.5)/2^LUT_DW)) / 2^LUT_DW.
  - Entries for i < 2^(LUT_DW-1) equal the i = 2^(LUT_DW-1) entry.
  - Generated at elaboration.
- Initialisation on accepted start:
  - b = s, Y = y0.
  - x = s·y0 for sqrt; x = y0 for inverse sqrt.
  - Iteration counter n = 0.
- States:
  - IDLE: on start_i, go to MULB, capture op, load b/Y/x, set err_q = (s_i[F_DW:F_DW-1] == 2'b00).
  - MULB: b ← b·Y·Y, go to COMPL.
  - COMPL: Y ← (3 − b)/2, i.e. 1.5 − (b>>1), go to MULX.
  - MULX: x ← x·Y, n ← n+1. If n+1 == ITERS, go to DONE; else go to MULB.
  - DONE: drive valid_o = 1 and load result_o, go to IDLE.
- Result formation:
  - result_o = x[FW : FW−(2*F_DW+1)], with the x integer bit taken as the result msb.
  - x never reaches 2.0 for in-range inputs.
  - If err_q is set, result_o = 0 and err_o = 1.
- start_i outside IDLE is ignored; no queuing, no error. op_i and s_i are don't-care outside the start cycle.
- result_o and err_o hold their value until the next DONE.

## Timing
- Reset values: result_o = 0, valid_o = 0, busy_o = 0, err_o = 0, state IDLE, internal registers 0.
- Start accepted at cycle 0 ⇒ valid_o high in cycle 3·ITERS+1. With defaults this is cycle 7.
- busy_o is high from cycle 1 through cycle 3·ITERS+1 inclusive.
- Next start is accepted no earlier than cycle 3·ITERS+2, i.e. back-to-back throughput of one op per 3·ITERS+2 cycles.
- rst asserted in any state:
  - Next cycle is IDLE with all outputs at reset values.
  - The in-flight operation is discarded with no valid_o.
- rst and start_i in the same cycle: rst wins and the start is dropped.

## Configuration
- LAMP_SQRT_ROUND_EN defined:
  - result_o is rounded to nearest, ties up.
  - Adds 1 at bit FW−(2*F_DW+1)−1 of x before slicing.
  - Saturates to all-ones if the sum overflows the result width.
- LAMP_SQRT_ROUND_EN undefined: result_o is a plain truncation of x; latency is identical either way.

## Test plan
- Exact value, sqrt, defaults: start, op=0, s_i=0x80 (1.0) → valid_o in cycle 7, result_o = 0x8000, err_o = 0.
- Non-exact inputs, each within ±4 LSB:
  - op=0, s_i=0x40 (0.5) → result_o ≈ 0x5A82.
  - op=1, s_i=0x40 → result_o ≈ 0xB505.
  - op=0, s_i=0xFF → result_o ≈ 0xB4AA.
- Out of range: s_i=0x20 → valid_o in cycle 7, err_o = 1, result_o = 0. Next op with s_i=0x80 clears err_o.
- Handshake:
  - start pulsed in cycles 0 and 3 → exactly one valid_o (cycle 7).
  - A start in cycle 8 is accepted and gives valid_o in cycle 15.
- Reset mid-op: rst in cycle 4 → cycle 5 busy_o = 0, and no valid_o in cycles 5–20.
- Parameter sweep: ITERS=1 and ITERS=3 → valid_o in cycles 4 and 10. With ITERS=3, the random-input error is ≤ 2 LSB versus a real-valued model; build both with and without LAMP_SQRT_ROUND_EN.

Source files
------------

// File: rtl/lamp_fpu_goldschmidt_sqrt.sv
// Iterative Goldschmidt sqrt / inverse-sqrt of a normalised mantissa in [0.5, 2).
// Define LAMP_SQRT_ROUND_EN to round the result to nearest (ties up) instead of truncating.
module lamp_fpu_goldschmidt_sqrt #(
  parameter int F_DW    = 7,
  parameter int PREC_DW = 8,
  parameter int LUT_DW  = 4,
  parameter int ITERS   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    op_i,
  input  logic [F_DW:0]           s_i,
  output logic [2*(F_DW+1)-1:0]   result_o,
  output logic                    valid_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int FW     = F_DW + PREC_DW;
  localparam int W      = FW + 2;
  localparam int RW     = 2 * (F_DW + 1);
  localparam int RSH    = FW - (RW - 1);
  localparam int LUT_N  = 2 ** (LUT_DW + 1);
  localparam int SEED_W = LUT_DW + 2;
  localparam logic [W-1:0] THREE_HALF = W'(3) << (FW - 1);

  typedef enum logic [2:0] {S_IDLE, S_MULB, S_COMPL, S_MULX, S_DONE} state_t;

  // round(2^L / sqrt((i+0.5)/2^L)) == round(sqrt(2^(3L+1)/(2i+1))), evaluated in integers:
  // the rounded root is the largest k with (2k-1)^2 * (2i+1) <= 2^(3L+3).
  function automatic logic [SEED_W-1:0] seed_calc(input int idx);
    longint d;
    longint n4;
    int     ii;
    logic [SEED_W-1:0] r;
    ii = (idx < 2 ** (LUT_DW - 1)) ? 2 ** (LUT_DW - 1) : idx;
    d  = longint'(2 * ii + 1);
    n4 = longint'(1) << (3 * LUT_DW + 3);
    r  = '0;
    for (int k = 1; k < 2 ** SEED_W; k++) begin
      if (longint'(2 * k - 1) * longint'(2 * k - 1) * d <= n4) r = SEED_W'(k);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] fx_mul(input logic [W-1:0] a, input logic [W-1:0] c);
    return W'(({{W{1'b0}}, a} * {{W{1'b0}}, c}) >> FW);
  endfunction

  logic [SEED_W-1:0] seed_rom [LUT_N];

  generate
    for (genvar gi = 0; gi < LUT_N; gi++) begin : g_seed
      assign seed_rom[gi] = seed_calc(gi);
    end
  endgenerate

  state_t          state_reg;
  state_t          state_next;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    y_reg;
  logic [W-1:0]    x_reg;
  logic [3:0]      iter_reg;
  logic            err_pend_reg;
  logic [RW-1:0]   result_reg;
  logic            err_reg;

  logic [LUT_DW:0] seed_idx;
  logic [W-1:0]    s_fix;
  logic [W-1:0]    y0_fix;
  logic [W-1:0]    x_mul;
  logic [RW-1:0]   res_fmt;
  logic            last_iter;

  assign seed_idx  = s_i[F_DW -: LUT_DW + 1];
  assign s_fix     = {1'b0, s_i, {PREC_DW{1'b0}}};
  assign y0_fix    = {seed_rom[seed_idx], {(FW - LUT_DW){1'b0}}};
  assign x_mul     = fx_mul(x_reg, y_reg);
  assign last_iter = ((iter_reg + 4'd1) == 4'(ITERS));

`ifdef LAMP_SQRT_ROUND_EN
  generate
    if (RSH > 0) begin : g_round
      localparam logic [W:0] RND_ONE = (W + 1)'(1) << (RSH - 1);
      logic [W:0] x_rnd;
      assign x_rnd   = {1'b0, x_mul} + RND_ONE;
      // Anything at or above bit FW+1 means the rounded value no longer fits 1.(2F+1).
      assign res_fmt = (x_rnd[W:FW+1] != 2'b00) ? {RW{1'b1}} : RW'(x_rnd >> RSH);
    end else begin : g_no_round
      assign res_fmt = RW'(x_mul >> RSH);
    end
  endgenerate
`else
  assign res_fmt = RW'(x_mul >> RSH);
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_i) state_next = S_MULB;
      S_MULB:  state_next = S_COMPL;
      S_COMPL: state_next = S_MULX;
      S_MULX:  state_next = last_iter ? S_DONE : S_MULB;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_reg        <= '0;
      y_reg        <= '0;
      x_reg        <= '0;
      iter_reg     <= '0;
      err_pend_reg <= 1'b0;
      result_reg   <= '0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start_i) begin
            b_reg        <= s_fix;
            y_reg        <= y0_fix;
            x_reg        <= op_i ? y0_fix : fx_mul(s_fix, y0_fix);
            iter_reg     <= '0;
            err_pend_reg <= (s_i[F_DW:F_DW-1] == 2'b00);
          end
        end
        S_MULB:  b_reg <= fx_mul(fx_mul(b_reg, y_reg), y_reg);
        S_COMPL: y_reg <= THREE_HALF - (b_reg >> 1);
        S_MULX: begin
          x_reg    <= x_mul;
          iter_reg <= iter_reg + 4'd1;
          // Output registers load on the way into DONE so they are valid with valid_o.
          if (last_iter) begin
            result_reg <= err_pend_reg ? '0 : res_fmt;
            err_reg    <= err_pend_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o = result_reg;
  assign err_o    = err_reg;
  assign valid_o  = (state_reg == S_DONE);
  assign busy_o   = (state_reg != S_IDLE);

endmodule
